// File: rtl/div_16_arbiter.sv
// div_16_arbiter: round-robin sharing of one div_16 divider among NREQ requesters,
// with a divide-by-zero short-cut and timeout recovery of a hung divider.
module div_16_arbiter #(
    parameter int NREQ        = 2,
    parameter int WIDTH       = 16,
    parameter int INIT_CYCLES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      result,
    output logic                  div_zero,
    output logic                  timeout,
    output logic                  busy,
    output logic                  div_init,
    output logic                  div_rst,
    output logic [WIDTH-1:0]      div_a,
    output logic [WIDTH-1:0]      div_b,
    input  logic [WIDTH-1:0]      div_result,
    input  logic                  div_done
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + INIT_CYCLES + 2);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, RECOVER} state_t;

    state_t          r_state, w_next;
    logic [IW-1:0]   r_gnt, r_ptr, w_sel, w_nptr;
    logic [CW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_res, r_a, r_b, w_a, w_b;
    logic            r_dz, r_to, w_found, w_bzero;

    // first pending request at or above the pointer, wrapping
    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_sel   = '0;
        w_a     = '0;
        w_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(r_ptr) + i) % NREQ;
            if (!w_found && req[IW'(j)]) begin
                w_found = 1'b1;
                w_sel   = IW'(j);
                w_a     = a_in[j*WIDTH +: WIDTH];
                w_b     = b_in[j*WIDTH +: WIDTH];
            end
        end
    end

    assign w_bzero = (w_b == '0);
    assign w_nptr  = (r_gnt == IW'(NREQ - 1)) ? '0 : r_gnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        busy     = (r_state != IDLE);
        div_init = (r_state == ISSUE);
        div_rst  = (r_state == RECOVER);
        ack      = (r_state == RESP) ? ({{(NREQ-1){1'b0}}, 1'b1} << r_gnt) : '0;
        result   = (r_state == RESP) ? r_res : '0;
        div_zero = (r_state == RESP) && r_dz;
        timeout  = (r_state == RESP) && r_to;
        case (r_state)
            IDLE:    w_next = !w_found ? IDLE : w_bzero ? RESP : ISSUE;
            ISSUE:   w_next = (r_cnt == CW'(INIT_CYCLES - 1)) ? WAIT : ISSUE;
            WAIT:    w_next = div_done ? RESP : (r_cnt == CW'(TIMEOUT)) ? RECOVER : WAIT;
            RECOVER: w_next = (r_cnt == CW'(1)) ? RESP : RECOVER;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // WAIT counts from 1 so that TIMEOUT is the number of cycles spent waiting
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else
            r_cnt <= (r_state != WAIT && w_next == WAIT) ? CW'(1) :
                     (r_state == IDLE || w_next != r_state) ? '0 : r_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt <= '0;
            r_ptr <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_dz  <= 1'b0;
            r_to  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_found) begin
                    r_gnt <= w_sel;
                    r_a   <= w_a;
                    r_b   <= w_b;
                    r_dz  <= w_bzero;
                    r_to  <= 1'b0;
                    r_res <= w_bzero ? '1 : '0;
                end
                WAIT: if (div_done) r_res <= div_result;
                RECOVER: begin
                    r_res <= '0;
                    r_to  <= 1'b1;
                end
                RESP: r_ptr <= w_nptr;
                default: ;
            endcase
        end
    end

    assign div_a = r_a;
    assign div_b = r_b;
endmodule

// File: tb/tb_div_16_arbiter.sv
// tb_div_16_arbiter: directed checks of the divider arbiter against a small
// behavioural div_16 stand-in that answers a few cycles after init drops.
module tb_div_16_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [31:0] a_in, b_in;
    logic [1:0]  ack;
    logic [15:0] result, div_a, div_b, div_result;
    logic        div_zero, timeout, busy, div_init, div_rst, div_done;

    logic        m_hang, m_run;
    logic [2:0]  m_cnt;
    logic [15:0] m_a, m_b;

    int total = 0;
    int passed = 0;
    int n_init, n_rst, n_wait;

    div_16_arbiter #(.NREQ(2), .WIDTH(16), .INIT_CYCLES(2), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .ack(ack), .result(result), .div_zero(div_zero), .timeout(timeout),
        .busy(busy), .div_init(div_init), .div_rst(div_rst),
        .div_a(div_a), .div_b(div_b), .div_result(div_result), .div_done(div_done)
    );

    always #5 clk = ~clk;

    // divider stand-in: reset by rst or div_rst, done 4 edges after init falls
    always_ff @(posedge clk) begin
        div_done <= 1'b0;
        if (rst || div_rst) begin
            m_run <= 1'b0;
            m_cnt <= '0;
        end else if (div_init) begin
            m_a   <= div_a;
            m_b   <= div_b;
            m_cnt <= 3'd4;
            m_run <= 1'b1;
        end else if (m_run) begin
            if (m_cnt == 3'd1) begin
                m_run      <= 1'b0;
                div_done   <= !m_hang;
                div_result <= (m_b == 0) ? 16'hFFFF : m_a / m_b;
            end else
                m_cnt <= m_cnt - 3'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_ack(output int inits, output int rsts, output int waits);
        inits = 0;
        rsts  = 0;
        waits = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ack != 2'b00) break;
            if (div_init) inits++;
            if (div_rst) rsts++;
            if (busy && !div_init && !div_rst) waits++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; a_in = '0; b_in = '0; m_hang = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_init", div_init, 0);
        chk("rst_diva", div_a, 0);
        chk("rst_result", result, 0);
        rst = 1'b0;

        // T1 single request: 300/50
        a_in = {16'd100, 16'h012C}; b_in = {16'd7, 16'h0032};
        req = 2'b01;
        wait_ack(n_init, n_rst, n_wait);
        req = 2'b00;
        chk("t1_ack", ack, 2'b01);
        chk("t1_result", result, 16'h0006);
        chk("t1_divzero", div_zero, 0);
        chk("t1_timeout", timeout, 0);
        chk("t1_init_cycles", n_init, 2);
        @(negedge clk);
        chk("t1_ack_clear", ack, 0);
        chk("t1_busy_clear", busy, 0);

        // T2 contention from pointer 0, both held: grants alternate 0,1,0,1
        do_reset();
        req = 2'b11;
        wait_ack(n_init, n_rst, n_wait);
        chk("t2_ack0", ack, 2'b01);
        chk("t2_res0", result, 16'd6);
        wait_ack(n_init, n_rst, n_wait);
        chk("t2_ack1", ack, 2'b10);
        chk("t2_res1", result, 16'd14);
        wait_ack(n_init, n_rst, n_wait);
        chk("t2_ack2", ack, 2'b01);
        wait_ack(n_init, n_rst, n_wait);
        chk("t2_ack3", ack, 2'b10);
        req = 2'b00;
        @(negedge clk);

        // T3 divide by zero on requester 1
        b_in = {16'd0, 16'd50};
        req = 2'b10;
        wait_ack(n_init, n_rst, n_wait);
        req = 2'b00;
        chk("t3_ack", ack, 2'b10);
        chk("t3_result", result, 16'hFFFF);
        chk("t3_divzero", div_zero, 1);
        chk("t3_timeout", timeout, 0);
        chk("t3_no_init", n_init, 0);
        chk("t3_fast", (n_wait + n_init + n_rst) <= 1, 1);
        @(negedge clk);
        chk("t3_flag_clear", div_zero, 0);

        // T4 hung divider, then a normal op
        b_in = {16'd7, 16'd50};
        m_hang = 1'b1;
        req = 2'b01;
        wait_ack(n_init, n_rst, n_wait);
        req = 2'b00;
        m_hang = 1'b0;
        chk("t4_ack", ack, 2'b01);
        chk("t4_result", result, 0);
        chk("t4_timeout", timeout, 1);
        chk("t4_divzero", div_zero, 0);
        chk("t4_wait_cycles", n_wait, 64);
        chk("t4_divrst_cycles", n_rst, 2);
        @(negedge clk);
        req = 2'b10;
        wait_ack(n_init, n_rst, n_wait);
        req = 2'b00;
        chk("t4b_ack", ack, 2'b10);
        chk("t4b_result", result, 16'd14);
        chk("t4b_timeout", timeout, 0);
        @(negedge clk);

        // T5 reset while requester 1 waits on the divider
        req = 2'b01;
        wait_ack(n_init, n_rst, n_wait);
        chk("t5_pre_ack", ack, 2'b01);
        req = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy && !div_init) break;
        end
        chk("t5_in_wait", {busy, div_init, ack}, 4'b1000);
        chk("t5_inflight_a", div_a, 16'd100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_ack", ack, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_diva", div_a, 0);
        chk("t5_rst_result", result, 0);
        wait_ack(n_init, n_rst, n_wait);
        req = 2'b10;
        chk("t5_regrant0", ack, 2'b01);
        chk("t5_regrant0_res", result, 16'd6);
        wait_ack(n_init, n_rst, n_wait);
        req = 2'b00;
        chk("t5_then1", ack, 2'b10);
        @(negedge clk);

        // T6 operands change after grant
        req = 2'b01;
        @(negedge clk);
        a_in = {16'd100, 16'd1000};
        b_in = {16'd7, 16'd3};
        chk("t6_captured_a", div_a, 16'd300);
        wait_ack(n_init, n_rst, n_wait);
        req = 2'b00;
        chk("t6_ack", ack, 2'b01);
        chk("t6_result", result, 16'd6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
